// File: rtl/arb_pkg.sv
// Shared types for the round-robin grant encoder.
// Holds the grant FSM state encoding and the priority-mode selectors.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational first-one search over req, starting at ptr and wrapping.
// Reports the winner as one-hot and binary index; no state.
module rr_pick #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam int SUM_W = IDX_W + 1;

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [SUM_W-1:0]     offset;
  logic [SUM_W-1:0]     sum;

  // NOTE: every variable gets a value before any conditional path, so no latch is inferred.
  always_comb begin
    offset  = '0;
    // Rotating the doubled vector puts requestor ptr at bit 0, so the scan is a plain first-one.
    doubled = {req, req} >> ptr;
    rotated = doubled[NUM_REQ-1:0];
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) offset = SUM_W'(k);
    end
    sum = {1'b0, ptr} + offset;
    if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
    any    = |req;
    idx    = any ? sum[IDX_W-1:0] : '0;
    onehot = any ? (NUM_REQ'(1) << sum) : '0;
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// Registered arbiter: picks one requestor (fixed or round-robin priority) and
// holds the grant as a valid/ready output until the consumer accepts it.
module rr_grant_encoder
  import arb_pkg::*;
#(
  parameter int NUM_REQ   = 8,
  parameter int IDX_W     = $clog2(NUM_REQ),
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               gnt_ready,
  output logic               gnt_valid,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx
);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("rr_grant_encoder: NUM_REQ must be at least 2");
  end
  if ((2 ** IDX_W) < NUM_REQ) begin : g_bad_idx_w
    $error("rr_grant_encoder: IDX_W too narrow for NUM_REQ");
  end

  localparam bit RR = (PRIO_MODE != PRIO_FIXED);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   onehot_q, onehot_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic                 handshake;
  logic [IDX_W-1:0]     ptr_adv;
  logic [IDX_W-1:0]     search_ptr;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  assign handshake = (state_q == GRANT) && gnt_ready;

  // Fixed priority never moves the pointer off requestor 0.
  assign ptr_adv = !RR ? '0 :
                   (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

  // A back-to-back grant must already search from the advanced pointer.
  assign search_ptr = handshake ? ptr_adv : ptr_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (search_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    onehot_d = onehot_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = GRANT;
          onehot_d = pick_onehot;
          idx_d    = pick_idx;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          ptr_d = ptr_adv;
          if (pick_any) begin
            onehot_d = pick_onehot;
            idx_d    = pick_idx;
          end else begin
            state_d  = IDLE;
            onehot_d = '0;
            idx_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      onehot_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
    end
  end

  assign gnt_valid  = (state_q == GRANT);
  assign gnt_onehot = onehot_q;
  assign gnt_idx    = idx_q;

endmodule

// File: doc/rr_grant_encoder.md
RR_GRANT_ENCODER -- requirements
Module: rr_grant_encoder

Interface
REQ-001 Parameter NUM_REQ, default 8: number of requestors; the block SHALL support any NUM_REQ >= 2, including non-powers of two.
REQ-002 Parameter IDX_W, default $clog2(NUM_REQ): binary index width; 2**IDX_W >= NUM_REQ SHALL hold, else elaboration error.
REQ-003 Parameter PRIO_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 clock  in  1  single clock; all state on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  NUM_REQ  request vector, bit i = requestor i.
REQ-007 gnt_ready  in  1  consumer accepts the current grant.
REQ-008 gnt_valid  out  1  a registered grant is presented.
REQ-009 gnt_onehot  out  NUM_REQ  one-hot grant, exactly one bit set when gnt_valid=1, zero otherwise.
REQ-010 gnt_idx  out  IDX_W  binary index of the set bit of gnt_onehot, zero when gnt_valid=0.

Function
REQ-011 Two states SHALL exist: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-012 IDLE: if |req, the winner SHALL be registered and the state SHALL go to GRANT; latency req->gnt_valid is 1 cycle. Otherwise stay in IDLE.
REQ-013 Winner search SHALL start at pointer ptr (IDX_W bits), scan ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1, and select the first set req bit.
REQ-014 PRIO_MODE=0: ptr SHALL be constant 0.
REQ-015 GRANT: gnt_onehot, gnt_idx and gnt_valid SHALL hold stable until gnt_valid & gnt_ready (handshake).
REQ-016 Deasserting the granted req bit while in GRANT SHALL NOT retract or change the grant.
REQ-017 On handshake, PRIO_MODE=1: ptr SHALL become gnt_idx+1, wrapping to 0 when gnt_idx = NUM_REQ-1; gnt_idx SHALL never exceed NUM_REQ-1.
REQ-018 On handshake with |req in the same cycle: the next winner SHALL be computed with the updated ptr and registered, staying in GRANT (back-to-back, one grant per cycle).
REQ-019 On handshake with req=0: the state SHALL go to IDLE, outputs zeroed the next cycle.
REQ-020 gnt_ready while gnt_valid=0 SHALL be ignored.
REQ-021 req changes in GRANT without a handshake SHALL have no effect until the handshake cycle.

Reset
REQ-022 While reset=1, immediately and independent of clock: gnt_valid=0, gnt_onehot=0, gnt_idx=0, ptr=0, state=IDLE.
REQ-023 Reset mid-grant SHALL discard the pending grant; no handshake is reported for it.
REQ-024 The first edge after reset release with |req SHALL produce a grant searched from ptr=0.

Structure
REQ-025 The state enum (IDLE, GRANT) SHALL be a typedef in the shared package arb_pkg.
REQ-026 The masked first-one search SHALL be one combinational sub-module, rr_pick (inputs req, ptr; outputs onehot, idx, any), used once.
REQ-027 All registers SHALL live in rr_grant_encoder; rr_pick SHALL contain no state.

Verification
REQ-028 Reset, req=0 for 20 cycles -> gnt_valid=0, gnt_onehot=0, gnt_idx=0 throughout.
REQ-029 NUM_REQ=8, PRIO_MODE=1, req=8'b1001_0100 held, gnt_ready=1 -> gnt_idx 2,4,7,2,4,7 on consecutive cycles, first one cycle after req.
REQ-030 req=8'h01 one cycle, gnt_ready=0 for 3 cycles then 1 -> gnt_onehot=8'h01, gnt_idx=0 stable 4 cycles; gnt_valid=0 the cycle after the handshake.
REQ-031 NUM_REQ=5, PRIO_MODE=1, req=5'b10001, gnt_ready=1 -> gnt_idx 0,4,0,4 (wrap 4->0); gnt_idx never 5..7.
REQ-032 PRIO_MODE=0, req=8'b1001_0100 held, gnt_ready=1 -> gnt_idx=2 every cycle.
REQ-033 reset pulsed while gnt_valid=1 with ptr=5 -> outputs zero before the next edge; after release, req=8'h81 -> gnt_idx=0.
